// File: rtl/shift_seq_unit_pkg.sv
// cpu_shift_pkg: shared encodings for the sequential shifter.
//   - 3-bit shift operation codes as seen on the op input
//   - FSM state encoding for shift_seq_unit
//   - shift-amount width for the default 32-bit datapath
// The rotate codes are always defined here. Whether they do anything is
// decided in shift_step under the SHIFT_ROTATE_EN macro.
package cpu_shift_pkg;

    // Shift-amount width for a 32-bit word (0..31 single-bit steps).
    localparam int SHAMT_W = 5;

    // Operation encodings. Codes 3'b110 and 3'b111 are reserved and behave
    // like SH_NOP.
    localparam logic [2:0] SH_NOP = 3'b000;
    localparam logic [2:0] SH_SLL = 3'b001;
    localparam logic [2:0] SH_SRL = 3'b010;
    localparam logic [2:0] SH_SRA = 3'b011;
    localparam logic [2:0] SH_ROL = 3'b100;
    localparam logic [2:0] SH_ROR = 3'b101;

    // FSM states. These are kept as plain constants so the encoding stays
    // stable for older code that compares raw state values.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // True for the shift codes that every build supports. Rotate support
    // is decided separately, inside shift_step.
    function automatic logic is_base_shift(input logic [2:0] op);
        return (op == SH_SLL) || (op == SH_SRL) || (op == SH_SRA);
    endfunction

endpackage

// File: rtl/shift_seq_unit_step.sv
// shift_step: purely combinational single-bit step of a WIDTH-bit word.
//   - Left-moving ops (SLL, ROL) feed each bit from its lower neighbour.
//   - Right-moving ops (SRL, SRA, ROR) feed each bit from its upper neighbour.
//   - The fill bit entering at the open end depends on the op.
//   - 'active' reports whether op is a real shift. When it is low, the
//     caller treats the operation as a NOP, and 'stepped' equals 'value'.
// Optional feature macro: SHIFT_ROTATE_EN.
//   - Defined: ROL and ROR are decoded and rotate the word.
//   - Undefined: codes 100 and 101 decode as NOP, and no rotate
//     fill paths exist.
module shift_step
    import cpu_shift_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] stepped,
    output logic             active
);

    logic             move_left;   // bits move toward the MSB
    logic             move_right;  // bits move toward the LSB
    logic             fill_lsb;    // bit entering at position 0 on a left move
    logic             fill_msb;    // bit entering at the MSB on a right move
    logic [WIDTH-1:0] from_lower;  // per-bit source for a left move
    logic [WIDTH-1:0] from_upper;  // per-bit source for a right move

    // Decode direction and fill bits for the requested op.
    always_comb begin
        move_left  = 1'b0;
        move_right = 1'b0;
        fill_lsb   = 1'b0;
        fill_msb   = 1'b0;
        case (op)
            SH_SLL: begin
                move_left = 1'b1;
                fill_lsb  = 1'b0;
            end
            SH_SRL: begin
                move_right = 1'b1;
                fill_msb   = 1'b0;
            end
            SH_SRA: begin
                // Sign bit replicates, so negative values saturate at all-ones.
                move_right = 1'b1;
                fill_msb   = value[WIDTH-1];
            end
`ifdef SHIFT_ROTATE_EN
            SH_ROL: begin
                move_left = 1'b1;
                fill_lsb  = value[WIDTH-1];
            end
            SH_ROR: begin
                move_right = 1'b1;
                fill_msb   = value[0];
            end
`endif
            default: begin
                // NOP, reserved codes and, without rotate support, ROL/ROR.
                move_left  = 1'b0;
                move_right = 1'b0;
            end
        endcase
    end

    // Build each output bit from its neighbours. The open ends take the fill bits.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign from_lower[gi] = fill_lsb;
            end else begin : g_mid_lo
                assign from_lower[gi] = value[gi-1];
            end

            if (gi == WIDTH - 1) begin : g_msb
                assign from_upper[gi] = fill_msb;
            end else begin : g_mid_hi
                assign from_upper[gi] = value[gi+1];
            end

            assign stepped[gi] = move_left  ? from_lower[gi] :
                                 move_right ? from_upper[gi] :
                                              value[gi];
        end
    endgenerate

    assign active = move_left | move_right;

endmodule

// File: rtl/shift_seq_unit.sv
// shift_seq_unit: sequential shift register driven by the multicycle
// control FSM.
//   - Shifts one bit per clock.
//   - Handshake: start (sampled only in IDLE), busy, and a one-cycle done pulse.
//   - data_out is the shift register itself and holds its value in IDLE.
// Latency: with start accepted at edge T, done is high in the cycle after
// edge T+shamt. That is one cycle after the start edge when shamt is zero
// or the op is a NOP.
// Optional feature macro: SHIFT_ROTATE_EN. The macro is handled inside
// shift_step. This level only asks shift_step whether an op is active.
module shift_seq_unit
    import cpu_shift_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [WIDTH-1:0]         data_in,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    input  logic [2:0]               op,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH-1:0]         data_out
);

    localparam int              SW        = $clog2(WIDTH);
    localparam logic [SW-1:0]   COUNT_ONE = SW'(1);

    logic [1:0]       state_reg, state_next;
    logic [WIDTH-1:0] data_reg,  data_next;
    logic [SW-1:0]    count_reg, count_next;
    logic [2:0]       op_reg,    op_next;

    logic [2:0]       step_op;
    logic [WIDTH-1:0] step_value;
    logic             step_active;

    // In IDLE, the step unit decodes the incoming op so that start can tell
    // a real shift from a NOP. In every other state it steps the latched op.
    // Its data output is only consumed in SHIFT, so sharing it is safe.
    always_comb begin
        step_op = (state_reg == ST_IDLE) ? op : op_reg;
    end

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op      (step_op),
        .value   (data_reg),
        .stepped (step_value),
        .active  (step_active)
    );

    // Next-state logic: FSM transitions, the step counter and the data register.
    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        count_next = count_reg;
        op_next    = op_reg;
        case (state_reg)
            ST_IDLE: begin
                if (load) begin
                    data_next = data_in;
                end
                if (start) begin
                    // When load and start come together, the op runs on the
                    // freshly loaded word. The first step happens at the next
                    // edge, so this needs no special handling.
                    op_next    = op;
                    count_next = shamt;
                    if ((shamt == '0) || !step_active) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                // load and start are ignored here. Only the step and count advance.
                data_next  = step_value;
                count_next = count_reg - COUNT_ONE;
                if (count_reg == COUNT_ONE) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State registers. Reset aborts any operation in progress and clears the
    // data register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            data_reg  <= '0;
            count_reg <= '0;
            op_reg    <= SH_NOP;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            count_reg <= count_next;
            op_reg    <= op_next;
        end
    end

    // Outputs come straight from the registers, so there are no
    // combinational paths from the inputs.
    always_comb begin
        busy     = (state_reg != ST_IDLE);
        done     = (state_reg == ST_DONE);
        data_out = data_reg;
    end

endmodule

// File: tb/tb_shift_seq_unit.sv
// Testbench for shift_seq_unit.
//   - The stimulus process pushes the expected result and the expected done
//     cycle into a scoreboard.
//   - A monitor pops one entry per done pulse and compares against it.
//   - Build with +define+SHIFT_ROTATE_EN to exercise the rotate variant.
module tb_shift_seq_unit;
    import cpu_shift_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic [2:0]  op;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] data_out;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] exp_data_q[$];
    int          exp_cyc_q[$];
    string       exp_name_q[$];

    shift_seq_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .data_in  (data_in),
        .shamt    (shamt),
        .op       (op),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    // Cycle counter: the number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: samples 2 ns after each rising edge and pops the scoreboard on done.
    initial begin : monitor
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (prev_done) begin
                check("busy_falls_after_done", {31'd0, busy}, 32'd0);
            end
            if (done === 1'b1) begin
                check("busy_during_done", {31'd0, busy}, 32'd1);
                if (exp_data_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done at cycle %0d expected no done", cyc);
                end else begin
                    string       nm;
                    logic [31:0] ed;
                    int          ec;
                    nm = exp_name_q.pop_front();
                    ed = exp_data_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    $display("txn %s: data_out=%h done_cycle=%0d", nm, data_out, cyc);
                    check({nm, "_data"}, data_out, ed);
                    check({nm, "_done_cycle"}, cyc, ec);
                end
            end
            prev_done = (done === 1'b1);
        end
    end

    // Queue an expected result; steps is the number of real shift cycles.
    task automatic expect_txn(input string name, input logic [31:0] exp, input int steps);
        exp_name_q.push_back(name);
        exp_data_q.push_back(exp);
        exp_cyc_q.push_back(cyc + 1 + steps);
    endtask

    // Issue one operation from a negedge in IDLE, wait for done, and count
    // the cycles in which busy is high. Returns at the negedge after done.
    task automatic do_op(input string name, input logic ld, input logic [31:0] val,
                         input logic [2:0] o, input logic [4:0] s,
                         input logic [31:0] exp, input int steps);
        int bcnt;
        bit seen;
        load    = ld;
        data_in = val;
        op      = o;
        shamt   = s;
        start   = 1'b1;
        expect_txn(name, exp, steps);
        @(negedge clk);
        load  = 1'b0;
        start = 1'b0;
        bcnt  = 0;
        seen  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (busy) bcnt++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no done expected done within 200 cycles", name);
        end
        check({name, "_busy_cycles"}, bcnt, steps + 1);
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200; i++) begin
            if (!busy) return;
            @(negedge clk);
        end
        checks++;
        failures++;
        $display("FAIL %s_idle_timeout: got busy expected idle within 200 cycles", name);
    endtask

    initial begin : stimulus
        reset   = 1'b1;
        load    = 1'b0;
        start   = 1'b0;
        data_in = '0;
        shamt   = '0;
        op      = SH_NOP;
        repeat (3) @(negedge clk);
        check("reset_data_out", data_out, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Basic left shift with load and start in the same cycle.
        do_op("sll4", 1'b1, 32'h0000_00F0, SH_SLL, 5'd4, 32'h0000_0F00, 4);
        // Arithmetic and logical right shifts at the maximum amount.
        do_op("sra31", 1'b1, 32'h8000_0000, SH_SRA, 5'd31, 32'hFFFF_FFFF, 31);
        do_op("srl31", 1'b1, 32'h8000_0000, SH_SRL, 5'd31, 32'h0000_0001, 31);
        // Zero shift amount, followed immediately by a back-to-back start.
        do_op("sll0", 1'b1, 32'h1234_5678, SH_SLL, 5'd0, 32'h1234_5678, 0);
        do_op("srl1_b2b", 1'b0, 32'h0, SH_SRL, 5'd1, 32'h091A_2B3C, 1);
        // NOP and reserved codes finish in one cycle and leave the register unchanged.
        do_op("nop5", 1'b1, 32'h55AA_55AA, SH_NOP, 5'd5, 32'h55AA_55AA, 0);
        do_op("rsv7", 1'b0, 32'h0, 3'b111, 5'd3, 32'h55AA_55AA, 0);

        // load and start while busy must not disturb the shift in progress.
        load    = 1'b1;
        data_in = 32'hF000_0000;
        op      = SH_SRL;
        shamt   = 5'd8;
        start   = 1'b1;
        expect_txn("srl8_ignore", 32'h00F0_0000, 8);
        @(negedge clk);
        load  = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        load    = 1'b1;
        data_in = 32'hDEAD_BEEF;
        op      = SH_SLL;
        shamt   = 5'd1;
        start   = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        start = 1'b0;
        wait_idle("srl8_ignore");
        @(negedge clk);

`ifdef SHIFT_ROTATE_EN
        do_op("ror4", 1'b1, 32'h0000_000F, SH_ROR, 5'd4, 32'hF000_0000, 4);
        do_op("rol4", 1'b1, 32'h8000_0001, SH_ROL, 5'd4, 32'h0000_0018, 4);
`else
        do_op("ror4", 1'b1, 32'h0000_000F, SH_ROR, 5'd4, 32'h0000_000F, 0);
        do_op("rol4", 1'b1, 32'h8000_0001, SH_ROL, 5'd4, 32'h8000_0001, 0);
`endif

        // Reset in the middle of a 10-step SLL: the op aborts and no done appears.
        load    = 1'b1;
        data_in = 32'h0000_0003;
        op      = SH_SLL;
        shamt   = 5'd10;
        start   = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_data_out", data_out, 32'd0);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check("abort_stays_idle", {31'd0, busy}, 32'd0);

        check("scoreboard_drained", exp_data_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so that the run always ends.
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/shift_seq_unit.md
# shift_seq_unit

Sequential 32-bit shift register that consumes the word chosen by the shift-input mux and shifts it one bit position per clock under control of the multicycle control unit. It sits between the shift-input/shift-amount multiplexers and the write-back mux. It provides logical left, logical right, arithmetic right and, optionally, rotate operations, with a start/busy/done handshake toward the control FSM.

## Interface
Parameters:
- `WIDTH`, 32, data width; `shamt` width is `$clog2(WIDTH)`.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  synchronous, active-high; one clock, one reset, no other clock domains.
- `load`  in  1  capture `data_in` into the shift register.
- `data_in`  in  WIDTH  word from the shift-input mux.
- `shamt`  in  5  shift amount from the shift-amount mux.
- `op`  in  3  operation: 000 NOP, 001 SLL, 010 SRL, 011 SRA, 100 ROL, 101 ROR; 110 and 111 reserved (treated as NOP).
- `start`  in  1  begin the operation; sampled only in IDLE.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse when the result is final.
- `data_out`  out  WIDTH  current shift-register contents.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - `load` = 1: register ← `data_in`.
  - `start` = 1: latch `op` and `shamt`, then `count` ← `shamt`.
    - `shamt` = 0 or `op` = NOP/reserved: go to DONE.
    - Otherwise: go to SHIFT.
  - `load` and `start` in the same cycle: the register takes `data_in`, and the operation runs on that value.
- SHIFT: at each edge apply one 1-bit step of the latched op, then `count` ← `count` − 1. When `count` = 1 before the step, go to DONE.
- Step rules:
  - SLL: {r[30:0], 0}.
  - SRL: {0, r[31:1]}.
  - SRA: {r[31], r[31:1]}.
  - ROL: {r[30:0], r[31]}.
  - ROR: {r[0], r[31:1]}.
- DONE: `done` = 1 for exactly one cycle, then IDLE unconditionally.
- `start` and `load` while busy are ignored. Register contents, latched op and latched count are all unaffected.
- `data_out` is always the register itself, with no output mux. It holds its value in IDLE until the next `load`.
- `shamt` is 5 bits, so the maximum is 31 steps and there is no wrap handling.
- SRA on a negative value saturates at 0xFFFFFFFF after 31 steps.

## Timing
- Reset values: state IDLE, `data_out` = 0, `busy` = 0, `done` = 0, `count` = 0, latched op = NOP.
- Reset mid-operation aborts immediately. The partial result is discarded and the register is zeroed.
- Latency: with the `start` edge at T, `done` is high during cycle T+`shamt`+1 (T+1 for `shamt` = 0). `data_out` is final in that same cycle.
- `busy` rises in the cycle after the `start` edge and falls in the cycle after `done`.
- The earliest back-to-back `start` is accepted in the cycle after `done`.
- `done` never coincides with IDLE. `busy` is high whenever `done` is high.

## Configuration
- `SHIFT_ROTATE_EN` defined: ROL and ROR are implemented as described.
- `SHIFT_ROTATE_EN` undefined:
  - Codes 100 and 101 decode as NOP: go to DONE in one cycle, register unchanged.
  - The rotate step logic is absent.

## Structure
- Package `cpu_shift_pkg` holds:
  - the 3-bit op encodings as localparams (`SH_NOP`, `SH_SLL`, `SH_SRL`, `SH_SRA`, `SH_ROL`, `SH_ROR`);
  - the state encoding;
  - the `SHAMT_W` constant.
- One sub-module, `shift_step`: purely combinational, one-bit step of a WIDTH-bit value for a given op. The macro guard on the rotate cases lives inside this sub-module.
- The top level contains only the FSM, `count` and the data register.

## Test plan
- Reset, then `load` 0x0000_00F0, `start` SLL `shamt` 4 → `done` at T+5, `data_out` = 0x0000_0F00; `busy` high for cycles T+1..T+5.
- `load` 0x8000_0000, `start` SRA `shamt` 31 → `done` at T+32, `data_out` = 0xFFFF_FFFF. Repeat with SRL → 0x0000_0001.
- `shamt` 0 with SLL on 0x1234_5678 → `done` at T+1, value unchanged. Next `start` is accepted in the cycle after `done`.
- `load` 0xDEAD_BEEF plus `start` while busy mid-SRL → both ignored, final result matches an uninterrupted run.
- Assert `reset` at cycle 3 of a 10-step SLL → next cycle `busy` = 0, `done` = 0, `data_out` = 0. No `done` pulse ever appears for the aborted operation.
- ROR `shamt` 4 on 0x0000_000F:
  - with `SHIFT_ROTATE_EN` → `data_out` = 0xF000_0000 at T+5;
  - without it → `done` at T+1 and 0x0000_000F retained.
